// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin grant encoder.
// Holds the arbiter state enum and the default N / watchdog limit.
package arb_pkg;

    // Default index width; requester count is 2**ARB_N_DEFAULT.
    localparam int ARB_N_DEFAULT       = 2;

    // Default watchdog limit, in GRANT cycles.
    localparam int ARB_TIMEOUT_DEFAULT = 16;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
// Ports: req (2**N request bits), ptr (highest-priority index),
//        any (some request set), idx (chosen requester index).
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = ARB_N_DEFAULT
) (
    input  logic [(1<<N)-1:0] req,
    input  logic [N-1:0]      ptr,
    output logic              any,
    output logic [N-1:0]      idx
);

    localparam int R = 1 << N;

    logic [R-1:0] rot;
    logic [N-1:0] enc;

    // Rotate right by ptr: rot[0] is requester ptr,
    // rot[1] is requester ptr+1, and so on, mod 2**N.
    always_comb begin
        rot = '0;
        for (int i = 0; i < R; i++) begin
            rot[i] = req[N'(i) + ptr];
        end
    end

    // Fixed priority: lowest set bit of the rotated vector.
    always_comb begin
        enc = '0;
        for (int i = R - 1; i >= 0; i--) begin
            if (rot[i]) begin
                enc = N'(i);
            end
        end
    end

    assign any = |req;

    // Undo the rotation; N-bit add wraps naturally.
    assign idx = enc + ptr;

endmodule : rr_pick

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter giving a registered binary grant index.
// Ports: clk, rst_n (sync, active-low), req, done,
//        grant_valid, grant_idx, timeout.
// Optional watchdog: define ARB_TIMEOUT_EN to enable it.
module rr_grant_encoder
    import arb_pkg::*;
#(
    parameter int N              = ARB_N_DEFAULT,
    parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [(1<<N)-1:0] req,
    input  logic              done,
    output logic              grant_valid,
    output logic [N-1:0]      grant_idx,
    output logic              timeout
);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("rr_grant_encoder: TIMEOUT_CYCLES must be >= 2");
    end

    arb_state_e   state_q;
    arb_state_e   state_d;
    logic [N-1:0] ptr_q;
    logic [N-1:0] ptr_d;
    logic [N-1:0] grant_idx_q;
    logic [N-1:0] grant_idx_d;
    logic         grant_valid_q;
    logic         grant_valid_d;

    logic         pick_any;
    logic [N-1:0] pick_idx;

    // Release request from the watchdog (0 when it is absent).
    logic         force_rel;

    rr_pick #(
        .N   (N)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

`ifdef ARB_TIMEOUT_EN

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          timeout_q;
    logic          timeout_d;

    assign cnt_inc = cnt_q + 1'b1;

    // Fires in the GRANT cycle that brings the count to the limit.
    assign force_rel = (state_q == ARB_GRANT)
                    && (cnt_inc == CW'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d     = '0;
        timeout_d = 1'b0;
        if (state_q == ARB_GRANT) begin
            cnt_d = cnt_inc;
            // done takes precedence; the pulse only marks a
            // release the grantee did not ask for.
            timeout_d = force_rel && !done;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;

`else

    assign force_rel = 1'b0;
    assign timeout   = 1'b0;

`endif

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        grant_idx_d   = grant_idx_q;
        grant_valid_d = grant_valid_q;

        unique case (state_q)
            ARB_IDLE: begin
                grant_valid_d = 1'b0;
                if (pick_any) begin
                    grant_idx_d   = pick_idx;
                    grant_valid_d = 1'b1;
                    state_d       = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                // req is ignored here; only a release moves us.
                if (done || force_rel) begin
                    grant_valid_d = 1'b0;
                    ptr_d         = grant_idx_q + 1'b1;
                    state_d       = ARB_IDLE;
                end
            end
            default: begin
                state_d       = ARB_IDLE;
                grant_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ARB_IDLE;
            ptr_q         <= '0;
            grant_idx_q   <= '0;
            grant_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_idx_q   <= grant_idx_d;
            grant_valid_q <= grant_valid_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_idx   = grant_idx_q;

endmodule : rr_grant_encoder

// File: tb/tb_rr_grant_encoder.sv
// Directed bench for rr_grant_encoder (N=2, TIMEOUT_CYCLES=4).
// Table of per-cycle vectors plus hand-written long-grant checks.
module tb_rr_grant_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       done;
        logic       exp_v;
        logic [1:0] exp_i;
        logic       exp_to;
    } vec_t;

    vec_t vecs[$];

    rr_grant_encoder #(
        .N              (2),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .done        (done),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [3:0] rq,
                       input logic d, input logic v,
                       input logic [1:0] i);
        vec_t t;
        t.rst_n  = r;
        t.req    = rq;
        t.done   = d;
        t.exp_v  = v;
        t.exp_i  = i;
        t.exp_to = 1'b0;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs for one cycle, then sample just after the edge.
    task automatic step(input logic r, input logic [3:0] rq,
                        input logic d);
        rst_n = r;
        req   = rq;
        done  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        @(posedge clk);
        #1;

        // reset, then idle with no requests
        add(0, 4'b0000, 0, 0, 2'd0);
        add(0, 4'b0000, 0, 0, 2'd0);
        for (int k = 0; k < 5; k++) add(1, 4'b0000, 0, 0, 2'd0);
        // 1010 from ptr 0 -> 1, then 3 after one idle cycle
        add(1, 4'b1010, 0, 1, 2'd1);
        add(1, 4'b1010, 0, 1, 2'd1);
        add(1, 4'b1010, 1, 0, 2'd1);
        add(1, 4'b1010, 0, 1, 2'd3);
        add(1, 4'b1010, 1, 0, 2'd3);
        // 1111 held: 0,1,2,3,0 with wrap of ptr
        add(1, 4'b1111, 0, 1, 2'd0);
        add(1, 4'b1111, 1, 0, 2'd0);
        add(1, 4'b1111, 0, 1, 2'd1);
        add(1, 4'b1111, 1, 0, 2'd1);
        add(1, 4'b1111, 0, 1, 2'd2);
        add(1, 4'b1111, 1, 0, 2'd2);
        add(1, 4'b1111, 0, 1, 2'd3);
        add(1, 4'b1111, 1, 0, 2'd3);
        add(1, 4'b1111, 0, 1, 2'd0);
        add(1, 4'b1111, 1, 0, 2'd0);
        // grant 2 frozen while req moves to 0001
        add(1, 4'b0100, 0, 1, 2'd2);
        add(1, 4'b0001, 0, 1, 2'd2);
        add(1, 4'b0000, 0, 1, 2'd2);
        add(1, 4'b0001, 1, 0, 2'd2);
        add(1, 4'b0001, 0, 1, 2'd0);
        add(1, 4'b0001, 1, 0, 2'd0);
        // done while idle is ignored (ptr stays 1)
        add(1, 4'b0000, 1, 0, 2'd0);
        add(1, 4'b0000, 1, 0, 2'd0);
        add(1, 4'b1101, 0, 1, 2'd2);
        add(1, 4'b1101, 1, 0, 2'd2);
        // reset mid-grant loses ptr history
        add(1, 4'b1111, 0, 1, 2'd3);
        add(0, 4'b1111, 0, 0, 2'd0);
        add(1, 4'b1111, 0, 1, 2'd0);
        add(1, 4'b1111, 1, 0, 2'd0);
        // done with new req: release first, then arbitrate from ptr
        add(1, 4'b0001, 0, 1, 2'd0);
        add(1, 4'b1111, 1, 0, 2'd0);
        add(1, 4'b1111, 0, 1, 2'd1);
        add(1, 4'b0000, 1, 0, 2'd1);
        add(1, 4'b0000, 0, 0, 2'd1);

        foreach (vecs[n]) begin
            step(vecs[n].rst_n, vecs[n].req, vecs[n].done);
            check($sformatf("v%0d_valid", n),
                  int'(grant_valid), int'(vecs[n].exp_v));
            check($sformatf("v%0d_idx", n),
                  int'(grant_idx), int'(vecs[n].exp_i));
            check($sformatf("v%0d_timeout", n),
                  int'(timeout), int'(vecs[n].exp_to));
        end

        // Long grant to index 1 with no done.
        step(0, 4'b0000, 0);
        step(1, 4'b0010, 0);
        check("long_start_valid", int'(grant_valid), 1);
        check("long_start_idx", int'(grant_idx), 1);

`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k <= 3; k++) begin
            step(1, 4'b0010, 0);
            check($sformatf("wd_hold%0d_valid", k), int'(grant_valid), 1);
            check($sformatf("wd_hold%0d_to", k), int'(timeout), 0);
        end
        step(1, 4'b1111, 0);
        check("wd_fire_valid", int'(grant_valid), 0);
        check("wd_fire_to", int'(timeout), 1);
        step(1, 4'b1111, 0);
        check("wd_next_valid", int'(grant_valid), 1);
        check("wd_next_idx", int'(grant_idx), 2);
        check("wd_pulse_end", int'(timeout), 0);
        // done on the limit cycle wins: no pulse
        for (int k = 1; k <= 3; k++) step(1, 4'b1111, 0);
        step(1, 4'b1111, 1);
        check("wd_tie_valid", int'(grant_valid), 0);
        check("wd_tie_to", int'(timeout), 0);
        step(1, 4'b1111, 0);
        check("wd_tie_next_idx", int'(grant_idx), 3);
`else
        for (int k = 1; k <= 20; k++) begin
            step(1, 4'b0010, 0);
            check($sformatf("hold%0d_valid", k), int'(grant_valid), 1);
            check($sformatf("hold%0d_to", k), int'(timeout), 0);
        end
        step(1, 4'b0000, 1);
        check("hold_rel_valid", int'(grant_valid), 0);
        step(1, 4'b1111, 0);
        check("hold_next_idx", int'(grant_idx), 2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_rr_grant_encoder
